// File: rtl/card_pkg.sv
// Shared constants, FSM state type and rank helpers for the card dealer.
package card_pkg;
  localparam int          NUM_RANKS = 13;
  localparam int          COPIES    = 4;
  localparam int          DECK_SIZE = 52;
  localparam logic [5:0]  RANK_NONE = 6'd63;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic {IDLE, PROBE} state_t;

  // Blackjack points: A=1, 2..9 face value, 10/J/Q/K=10, blank=0.
  function automatic logic [3:0] rank_points(input logic [5:0] rank);
    logic [3:0] p;
    p = 4'd0;
    if (rank == 6'd0)       p = 4'd1;
    else if (rank <= 6'd8)  p = rank[3:0] + 4'd1;
    else if (rank <= 6'd12) p = 4'd10;
    return p;
  endfunction

  // Fold a 4-bit random nibble onto 0..12 (13..15 wrap to 0..2).
  function automatic logic [3:0] fold_rank(input logic [3:0] v);
    return (v >= 4'd13) ? v - 4'd13 : v;
  endfunction
endpackage

// File: rtl/card_dealer_lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed is swapped for 1 so it never locks up.
module lfsr16
  import card_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);
  localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

  // Shift right every cycle, folding the mask in when the outgoing bit is 1.
  always_ff @(posedge clk) begin
    if (reset)     q <= INIT;
    else if (q[0]) q <= (q >> 1) ^ LFSR_MASK;
    else           q <= q >> 1;
  end
endmodule

// File: rtl/card_dealer.sv
// Single-deck card source: random start rank, linear probe to the next rank
// with copies left, registered rank/points/occupancy outputs.
module card_dealer
  import card_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       deal_req,
  input  logic       shuffle_req,
  output logic       card_valid,
  output logic [5:0] card_rank,
  output logic [3:0] card_points,
  output logic [5:0] cards_left,
  output logic       deck_empty,
  output logic       busy,
  output logic       deal_err
);
  logic [15:0] lfsr_q;
  state_t      state;
  logic [3:0]  cand;
  logic [2:0]  count [NUM_RANKS];

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .reset(reset),
    .q    (lfsr_q)
  );

  // Deck counters and deal FSM; shuffle wins over everything in either state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cand        <= 4'd0;
      card_valid  <= 1'b0;
      card_rank   <= RANK_NONE;
      card_points <= 4'd0;
      cards_left  <= 6'(DECK_SIZE);
      deck_empty  <= 1'b0;
      busy        <= 1'b0;
      deal_err    <= 1'b0;
      for (int i = 0; i < NUM_RANKS; i++) count[i] <= 3'(COPIES);
    end else begin
      card_valid <= 1'b0;
      deal_err   <= 1'b0;
      if (shuffle_req) begin
        // Refill; a pending deal (if any) is abandoned without a card.
        state       <= IDLE;
        busy        <= 1'b0;
        card_rank   <= RANK_NONE;
        card_points <= 4'd0;
        cards_left  <= 6'(DECK_SIZE);
        deck_empty  <= 1'b0;
        for (int i = 0; i < NUM_RANKS; i++) count[i] <= 3'(COPIES);
      end else begin
        case (state)
          IDLE: begin
            if (deal_req) begin
              if (cards_left == 6'd0) begin
                deal_err <= 1'b1;
              end else begin
                cand  <= fold_rank(lfsr_q[3:0]);
                state <= PROBE;
                busy  <= 1'b1;
              end
            end
          end
          PROBE: begin
            if (count[cand] != 3'd0) begin
              count[cand] <= count[cand] - 3'd1;
              cards_left  <= cards_left - 6'd1;
              deck_empty  <= (cards_left == 6'd1);
              card_rank   <= {2'b00, cand};
              card_points <= rank_points({2'b00, cand});
              card_valid  <= 1'b1;
              busy        <= 1'b0;
              state       <= IDLE;
            end else begin
              // Rank exhausted: walk to the next one, wrapping K back to A.
              cand <= (cand == 4'd12) ? 4'd0 : cand + 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
